// File: rtl/mx_format_pkg.sv
// MX format definitions: format codes, element/vector types, per-format element
// width and scale location helpers shared by the operand sequencer.
package mx_format_pkg;

    localparam int NUM_ELEMS           = 32;
    localparam int ELEM_BITS           = 8;
    localparam int LARGEST_VECTOR_SIZE = NUM_ELEMS * ELEM_BITS + 8;
    localparam logic [7:0] SCALE_NAN   = 8'hFF;

    typedef logic [ELEM_BITS-1:0]           mx_elem_t;
    typedef logic [LARGEST_VECTOR_SIZE-1:0] mx_vec_t;

    typedef enum logic [2:0] {
        FMT_E5M2 = 3'd0,
        FMT_E4M3 = 3'd1,
        FMT_E3M2 = 3'd2,
        FMT_E2M3 = 3'd3,
        FMT_E2M1 = 3'd4,
        FMT_INT8 = 3'd5
    } mx_fmt_e;

    function automatic logic fmt_legal(input logic [2:0] fmt);
        return fmt <= 3'd5;
    endfunction

    // Returns 0 for the two unused codes so callers can treat them as "no data".
    function automatic logic [3:0] elem_width(input logic [2:0] fmt);
        case (mx_fmt_e'(fmt))
            FMT_E5M2, FMT_E4M3, FMT_INT8: return 4'd8;
            FMT_E3M2, FMT_E2M3:           return 4'd6;
            FMT_E2M1:                     return 4'd4;
            default:                      return 4'd0;
        endcase
    endfunction

    // The scale byte sits directly above the 32 packed elements.
    function automatic logic [7:0] scale_of(input mx_vec_t vec, input logic [2:0] fmt);
        case (elem_width(fmt))
            4'd8:    return vec[NUM_ELEMS*8 +: 8];
            4'd6:    return vec[NUM_ELEMS*6 +: 8];
            4'd4:    return vec[NUM_ELEMS*4 +: 8];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mx_elem_extract.sv
// Picks element idx out of a packed MX vector and zero-extends it to 8 bits.
module mx_elem_extract
    import mx_format_pkg::*;
(
    input  logic [LARGEST_VECTOR_SIZE-1:0] vec,
    input  logic [2:0]                     fmt,
    input  logic [4:0]                     idx,
    output logic [7:0]                     elem
);

    logic [8:0] bit_base;

    always_comb begin
        bit_base = '0;
        elem     = '0;
        case (elem_width(fmt))
            4'd8: begin
                bit_base = {1'b0, idx, 3'b000};
                elem     = vec[bit_base +: 8];
            end
            4'd6: begin
                bit_base = 9'({idx, 2'b00}) + 9'({idx, 1'b0});
                elem     = {2'b00, vec[bit_base +: 6]};
            end
            4'd4: begin
                bit_base = 9'({idx, 2'b00});
                elem     = {4'b0000, vec[bit_base +: 4]};
            end
            default: begin
                bit_base = '0;
                elem     = '0;
            end
        endcase
    end

endmodule

// File: rtl/mx_operand_sequencer.sv
// Latches an MX operand pair and streams its 32 element pairs LANES at a time.
// Optional MX_SEQ_SCALE_SUM_EN adds the combined-exponent outputs scale_sum/scale_nan.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for an operand pair, in_ready=1
//   ISSUE | streaming beats of the latched block, el_valid=1
module mx_operand_sequencer
    import mx_format_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     in_fmt,
    input  logic [LARGEST_VECTOR_SIZE-1:0] in_vec_a,
    input  logic [LARGEST_VECTOR_SIZE-1:0] in_vec_b,
    output logic                           el_valid,
    input  logic                           el_ready,
    output logic [8*LANES-1:0]             el_a,
    output logic [8*LANES-1:0]             el_b,
    output logic [4:0]                     el_idx,
    output logic                           el_last,
    output logic [2:0]                     el_fmt,
    output logic [7:0]                     scale_a,
    output logic [7:0]                     scale_b,
    output logic                           fmt_err,
`ifdef MX_SEQ_SCALE_SUM_EN
    output logic signed [9:0]              scale_sum,
    output logic                           scale_nan,
`endif
    output logic                           busy
);

    localparam logic [4:0] IDX_STEP = 5'(LANES);
    localparam logic [4:0] LAST_IDX = 5'(NUM_ELEMS - LANES);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e     state;
    mx_vec_t    vec_a_q;
    mx_vec_t    vec_b_q;
    logic [7:0] in_scale_a;
    logic [7:0] in_scale_b;

    assign in_scale_a = scale_of(in_vec_a, in_fmt);
    assign in_scale_b = scale_of(in_vec_b, in_fmt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            el_valid  <= 1'b0;
            el_last   <= 1'b0;
            el_idx    <= '0;
            el_fmt    <= '0;
            scale_a   <= '0;
            scale_b   <= '0;
            fmt_err   <= 1'b0;
            busy      <= 1'b0;
            vec_a_q   <= '0;
            vec_b_q   <= '0;
`ifdef MX_SEQ_SCALE_SUM_EN
            scale_sum <= '0;
            scale_nan <= 1'b0;
`endif
        end else begin
            fmt_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (fmt_legal(in_fmt)) begin
                            state     <= ISSUE;
                            in_ready  <= 1'b0;
                            el_valid  <= 1'b1;
                            busy      <= 1'b1;
                            el_idx    <= '0;
                            el_last   <= (LAST_IDX == 5'd0);
                            el_fmt    <= in_fmt;
                            vec_a_q   <= in_vec_a;
                            vec_b_q   <= in_vec_b;
                            scale_a   <= in_scale_a;
                            scale_b   <= in_scale_b;
`ifdef MX_SEQ_SCALE_SUM_EN
                            scale_sum <= $signed({2'b00, in_scale_a}) + $signed({2'b00, in_scale_b})
                                         - 10'sd254;
                            scale_nan <= (in_scale_a == SCALE_NAN) || (in_scale_b == SCALE_NAN);
`endif
                        end else begin
                            fmt_err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (el_ready) begin
                        // idx wraps to 0 after the final beat, which also clears el_last
                        el_idx  <= el_idx + IDX_STEP;
                        el_last <= ((el_idx + IDX_STEP) == LAST_IDX);
                        if (el_last) begin
                            state    <= IDLE;
                            el_valid <= 1'b0;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [4:0] lane_idx;
        assign lane_idx = el_idx + 5'(k);

        mx_elem_extract u_extract_a (
            .vec  (vec_a_q),
            .fmt  (el_fmt),
            .idx  (lane_idx),
            .elem (el_a[8*k +: 8])
        );

        mx_elem_extract u_extract_b (
            .vec  (vec_b_q),
            .fmt  (el_fmt),
            .idx  (lane_idx),
            .elem (el_b[8*k +: 8])
        );
    end

endmodule

// File: tb/tb_mx_operand_sequencer.sv
// Bench for mx_operand_sequencer: a LANES=1 and a LANES=4 instance checked
// against a beat scoreboard built from the element values driven in.
module tb_mx_operand_sequencer;
    import mx_format_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  idx;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       in_valid_drv = 1'b0;
    logic       ready_drv = 1'b0;
    logic [2:0] fmt_drv = 3'd0;
    mx_vec_t    va_drv = '0;
    mx_vec_t    vb_drv = '0;

    logic in_valid1, in_ready1, el_valid1, el_ready1, el_last1, fmt_err1, busy1;
    logic [7:0] el_a1, el_b1, scale_a1, scale_b1;
    logic [4:0] el_idx1;
    logic [2:0] el_fmt1;
    logic in_valid4, in_ready4, el_valid4, el_ready4, el_last4, fmt_err4, busy4;
    logic [31:0] el_a4, el_b4;
    logic [7:0]  scale_a4, scale_b4;
    logic [4:0]  el_idx4;
    logic [2:0]  el_fmt4;
`ifdef MX_SEQ_SCALE_SUM_EN
    logic signed [9:0] scale_sum1, scale_sum4;
    logic              scale_nan1, scale_nan4;
`endif

    assign in_valid1 = in_valid_drv & ~sel;
    assign in_valid4 = in_valid_drv & sel;
    assign el_ready1 = ready_drv & ~sel;
    assign el_ready4 = ready_drv & sel;

    logic        obs_valid, obs_last, obs_in_ready, obs_busy, obs_fmt_err;
    logic [31:0] obs_a, obs_b;
    logic [4:0]  obs_idx;
    logic [2:0]  obs_fmt;
    logic [7:0]  obs_sa, obs_sb;
    assign obs_valid    = sel ? el_valid4 : el_valid1;
    assign obs_last     = sel ? el_last4  : el_last1;
    assign obs_in_ready = sel ? in_ready4 : in_ready1;
    assign obs_busy     = sel ? busy4     : busy1;
    assign obs_fmt_err  = sel ? fmt_err4  : fmt_err1;
    assign obs_a        = sel ? el_a4     : {24'd0, el_a1};
    assign obs_b        = sel ? el_b4     : {24'd0, el_b1};
    assign obs_idx      = sel ? el_idx4   : el_idx1;
    assign obs_fmt      = sel ? el_fmt4   : el_fmt1;
    assign obs_sa       = sel ? scale_a4  : scale_a1;
    assign obs_sb       = sel ? scale_b4  : scale_b1;

    mx_operand_sequencer #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_fmt(fmt_drv), .in_vec_a(va_drv), .in_vec_b(vb_drv),
        .el_valid(el_valid1), .el_ready(el_ready1), .el_a(el_a1), .el_b(el_b1),
        .el_idx(el_idx1), .el_last(el_last1), .el_fmt(el_fmt1),
        .scale_a(scale_a1), .scale_b(scale_b1), .fmt_err(fmt_err1),
`ifdef MX_SEQ_SCALE_SUM_EN
        .scale_sum(scale_sum1), .scale_nan(scale_nan1),
`endif
        .busy(busy1)
    );

    mx_operand_sequencer #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_fmt(fmt_drv), .in_vec_a(va_drv), .in_vec_b(vb_drv),
        .el_valid(el_valid4), .el_ready(el_ready4), .el_a(el_a4), .el_b(el_b4),
        .el_idx(el_idx4), .el_last(el_last4), .el_fmt(el_fmt4),
        .scale_a(scale_a4), .scale_b(scale_b4), .fmt_err(fmt_err4),
`ifdef MX_SEQ_SCALE_SUM_EN
        .scale_sum(scale_sum4), .scale_nan(scale_nan4),
`endif
        .busy(busy4)
    );

    beat_t      sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] ea[32];
    logic [7:0] eb[32];

    function automatic int tb_width(input logic [2:0] f);
        case (f)
            3'd0, 3'd1, 3'd5: return 8;
            3'd2, 3'd3:       return 6;
            3'd4:             return 4;
            default:          return 0;
        endcase
    endfunction

    task automatic build_vec(input logic [2:0] f, input logic [7:0] sa, input logic [7:0] sbs);
        int w;
        w = tb_width(f);
        va_drv = '0;
        vb_drv = '0;
        for (int i = 0; i < 32; i++)
            for (int b = 0; b < w; b++) begin
                va_drv[i*w+b] = ea[i][b];
                vb_drv[i*w+b] = eb[i][b];
            end
        for (int b = 0; b < 8; b++) begin
            va_drv[32*w+b] = sa[b];
            vb_drv[32*w+b] = sbs[b];
        end
        for (int j = 32*w + 8; j < LARGEST_VECTOR_SIZE; j++) begin
            va_drv[j] = 1'($urandom_range(1));
            vb_drv[j] = 1'($urandom_range(1));
        end
    endtask

    task automatic push_block(input int lanes, input logic [2:0] f);
        beat_t      bt;
        logic [7:0] m;
        m = 8'((1 << tb_width(f)) - 1);
        for (int idx = 0; idx < 32; idx += lanes) begin
            bt.a = '0;
            bt.b = '0;
            for (int k = 0; k < lanes; k++) begin
                bt.a[8*k +: 8] = ea[idx+k] & m;
                bt.b[8*k +: 8] = eb[idx+k] & m;
            end
            bt.idx  = 5'(idx);
            bt.last = (idx == 32 - lanes);
            sb.push_back(bt);
        end
    endtask

    task automatic offer(input logic [2:0] f, input logic [7:0] sa, input logic [7:0] sbs);
        int guard;
        guard = 0;
        build_vec(f, sa, sbs);
        fmt_drv = f;
        in_valid_drv = 1'b1;
        while (!obs_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            failures++;
            $display("FAIL offer_timeout in_ready=%b required=1", obs_in_ready);
        end
        @(negedge clk);
        in_valid_drv = 1'b0;
        va_drv = ~va_drv;
        vb_drv = ~vb_drv;
        fmt_drv = 3'd7;
        checks++;
        if (obs_valid !== 1'b1 || obs_busy !== 1'b1 || obs_in_ready !== 1'b0 || obs_idx !== 5'd0) begin
            failures++;
            $display("FAIL first_beat valid=%b busy=%b in_ready=%b idx=%0d required 1 1 0 0",
                     obs_valid, obs_busy, obs_in_ready, obs_idx);
        end
        checks++;
        if (obs_sa !== sa || obs_sb !== sbs || obs_fmt !== f) begin
            failures++;
            $display("FAIL block_regs scale_a=%h/%h scale_b=%h/%h fmt=%0d/%0d (got/required)",
                     obs_sa, sa, obs_sb, sbs, obs_fmt, f);
        end
    endtask

    // mode 0: el_ready held high; mode 1: el_ready low, high, low, ...
    task automatic run_block(input int mode, output int cycles);
        beat_t       exp;
        logic        have_prev;
        logic [31:0] pa, pb;
        logic [4:0]  pi;
        logic        pl;
        cycles = 0;
        have_prev = 1'b0;
        pa = '0; pb = '0; pi = '0; pl = 1'b0;
        while (sb.size() > 0 && cycles < 400) begin
            ready_drv = (mode == 0) || (cycles % 2 == 1);
            if (have_prev) begin
                checks++;
                if ({obs_valid, obs_a, obs_b, obs_idx, obs_last} !== {1'b1, pa, pb, pi, pl}) begin
                    failures++;
                    $display("FAIL stall_hold valid=%b a=%h/%h b=%h/%h idx=%0d/%0d last=%b/%b (got/required)",
                             obs_valid, obs_a, pa, obs_b, pb, obs_idx, pi, obs_last, pl);
                end
            end
            if (obs_valid) begin
                exp = sb[0];
                checks++;
                if (obs_a !== exp.a || obs_b !== exp.b || obs_idx !== exp.idx || obs_last !== exp.last) begin
                    failures++;
                    $display("FAIL beat a=%h/%h b=%h/%h idx=%0d/%0d last=%b/%b (got/required)",
                             obs_a, exp.a, obs_b, exp.b, obs_idx, exp.idx, obs_last, exp.last);
                end
                if (ready_drv) void'(sb.pop_front());
            end
            have_prev = obs_valid && !ready_drv;
            pa = obs_a; pb = obs_b; pi = obs_idx; pl = obs_last;
            cycles++;
            @(negedge clk);
        end
        ready_drv = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL block_timeout beats_left=%0d required=0", sb.size());
            sb.delete();
        end
        checks++;
        if (obs_in_ready !== 1'b1 || obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
            failures++;
            $display("FAIL end_idle in_ready=%b valid=%b busy=%b required 1 0 0",
                     obs_in_ready, obs_valid, obs_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (el_valid1 !== 1'b0 || el_valid4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid valid1=%b valid4=%b required 0", el_valid1, el_valid4);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            checks++;
            if (obs_in_ready !== 1'b1 || obs_valid !== 1'b0 || obs_last !== 1'b0 || obs_idx !== 5'd0
                || obs_busy !== 1'b0 || obs_fmt_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_ctrl lanes_sel=%0d in_ready=%b valid=%b last=%b idx=%0d busy=%b fmt_err=%b",
                         s, obs_in_ready, obs_valid, obs_last, obs_idx, obs_busy, obs_fmt_err);
            end
            checks++;
            if (obs_a !== 32'd0 || obs_b !== 32'd0 || obs_sa !== 8'd0 || obs_sb !== 8'd0 || obs_fmt !== 3'd0) begin
                failures++;
                $display("FAIL reset_data a=%h b=%h scale_a=%h scale_b=%h fmt=%0d required all 0",
                         obs_a, obs_b, obs_sa, obs_sb, obs_fmt);
            end
        end
`ifdef MX_SEQ_SCALE_SUM_EN
        checks++;
        if (scale_sum1 !== 10'sd0 || scale_nan1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_scale_sum sum=%0d nan=%b required 0 0", scale_sum1, scale_nan1);
        end
`endif
    endtask

    task automatic test_int8_lanes1();
        int cyc;
        sel = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            ea[i] = 8'(i);
            eb[i] = 8'hFF - 8'(i);
        end
        push_block(1, 3'd5);
        offer(3'd5, 8'h10, 8'h20);
        run_block(0, cyc);
        checks++;
        if (cyc != 32) begin
            failures++;
            $display("FAIL int8_cycles got=%0d required=32", cyc);
        end
    endtask

    task automatic test_fp4_lanes4();
        int cyc;
        sel = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            ea[i] = 8'h0A;
            eb[i] = 8'(i) & 8'h0F;
        end
        push_block(4, 3'd4);
        offer(3'd4, 8'h7F, 8'h01);
        checks++;
        if (el_a4 !== 32'h0A0A0A0A) begin
            failures++;
            $display("FAIL fp4_lane_pack got=%h required=0a0a0a0a", el_a4);
        end
        run_block(0, cyc);
        checks++;
        if (cyc != 8 || scale_a4 !== 8'h7F) begin
            failures++;
            $display("FAIL fp4_block cycles=%0d/8 scale_a=%h/7f (got/required)", cyc, scale_a4);
        end
    endtask

    task automatic test_stall();
        int cyc;
        sel = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            ea[i] = 8'($urandom_range(63));
            eb[i] = 8'($urandom_range(63));
        end
        push_block(1, 3'd2);
        offer(3'd2, 8'h33, 8'h44);
        run_block(1, cyc);
        checks++;
        if (cyc != 64) begin
            failures++;
            $display("FAIL stall_cycles got=%0d required=64", cyc);
        end
    endtask

    task automatic test_fmt_err();
        logic [2:0] prev_fmt;
        logic [7:0] prev_sa;
        sel = 1'b0;
        #1;
        prev_fmt = el_fmt1;
        prev_sa  = scale_a1;
        for (int f = 6; f < 8; f++) begin
            fmt_drv = 3'(f);
            va_drv = {33{8'hC3}};
            in_valid_drv = 1'b1;
            @(negedge clk);
            in_valid_drv = 1'b0;
            checks++;
            if (fmt_err1 !== 1'b1 || busy1 !== 1'b0 || in_ready1 !== 1'b1 || el_valid1 !== 1'b0) begin
                failures++;
                $display("FAIL fmt_err_pulse fmt=%0d fmt_err=%b busy=%b in_ready=%b valid=%b required 1 0 1 0",
                         f, fmt_err1, busy1, in_ready1, el_valid1);
            end
            checks++;
            if (el_fmt1 !== prev_fmt || scale_a1 !== prev_sa) begin
                failures++;
                $display("FAIL fmt_err_hold fmt=%0d/%0d scale_a=%h/%h (got/required)",
                         el_fmt1, prev_fmt, scale_a1, prev_sa);
            end
            @(negedge clk);
            checks++;
            if (fmt_err1 !== 1'b0 || el_valid1 !== 1'b0) begin
                failures++;
                $display("FAIL fmt_err_width fmt_err=%b valid=%b required 0 0", fmt_err1, el_valid1);
            end
        end
    endtask

    task automatic test_reset_mid_block();
        int cyc;
        int guard;
        sel = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            ea[i] = 8'($urandom_range(255));
            eb[i] = 8'($urandom_range(255));
        end
        push_block(1, 3'd5);
        offer(3'd5, 8'h05, 8'h06);
        ready_drv = 1'b1;
        guard = 0;
        while (el_idx1 != 5'd12 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (el_idx1 !== 5'd12) begin
            failures++;
            $display("FAIL reach_idx12 got=%0d required=12", el_idx1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (el_valid1 !== 1'b0 || busy1 !== 1'b0 || el_idx1 !== 5'd0) begin
            failures++;
            $display("FAIL async_reset valid=%b busy=%b idx=%0d required 0 0 0", el_valid1, busy1, el_idx1);
        end
        sb.delete();
        ready_drv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready1 !== 1'b1 || el_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset in_ready=%b valid=%b required 1 0", in_ready1, el_valid1);
        end
        push_block(1, 3'd1);
        offer(3'd1, 8'h11, 8'h22);
        run_block(0, cyc);
    endtask

`ifdef MX_SEQ_SCALE_SUM_EN
    task automatic test_scale_sum();
        int cyc;
        sel = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            ea[i] = 8'(3 * i);
            eb[i] = 8'(5 * i);
        end
        push_block(4, 3'd0);
        offer(3'd0, 8'h80, 8'h7E);
        checks++;
        if (scale_sum4 !== 10'sd0 || scale_nan4 !== 1'b0) begin
            failures++;
            $display("FAIL scale_sum_zero sum=%0d nan=%b required 0 0", scale_sum4, scale_nan4);
        end
        run_block(0, cyc);
        push_block(4, 3'd0);
        offer(3'd0, 8'hFF, 8'h01);
        checks++;
        if (scale_sum4 !== 10'sd2 || scale_nan4 !== 1'b1) begin
            failures++;
            $display("FAIL scale_nan sum=%0d nan=%b required 2 1", scale_sum4, scale_nan4);
        end
        run_block(0, cyc);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_int8_lanes1();
        test_fp4_lanes4();
        test_stall();
        test_fmt_err();
        test_reset_mid_block();
`ifdef MX_SEQ_SCALE_SUM_EN
        test_scale_sum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mx_operand_sequencer.md
MX_OPERAND_SEQUENCER -- requirements
Module: mx_operand_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 1, giving element pairs issued per beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have ports:
  clk  in  1  clock, all logic on rising edge
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  operand pair offered
  in_ready  out  1  sequencer can accept operands
  in_fmt  in  3  format code
  in_vec_a  in  LARGEST_VECTOR_SIZE  MX vector A
  in_vec_b  in  LARGEST_VECTOR_SIZE  MX vector B
  el_valid  out  1  element beat valid
  el_ready  in  1  downstream ALU accepts beat
  el_a  out  8*LANES  A elements, raw bits zero-extended to 8 per lane
  el_b  out  8*LANES  B elements, same layout
  el_idx  out  5  index of lane 0 element
  el_last  out  1  final beat of block
  el_fmt  out  3  format of current block
  scale_a  out  8  A block scale, held for the block
  scale_b  out  8  B block scale, held for the block
  fmt_err  out  1  one-cycle pulse: illegal format dropped
  busy  out  1  block in progress

Function
REQ-003 Format codes SHALL be: 0 E5M2, 1 E4M3, 2 E3M2, 3 E2M3, 4 E2M1, 5 INT8; 6 and 7 illegal.
REQ-004 Element width W SHALL be 8 for codes 0/1/5, 6 for 2/3, 4 for 4.
REQ-005 Element i SHALL occupy vec[i*W +: W]; scale SHALL occupy vec[32*W +: 8]; bits above SHALL be ignored.
REQ-006 FSM states SHALL be IDLE, ISSUE, with transitions IDLE->ISSUE on in_valid&in_ready with legal fmt, ISSUE->IDLE on accepted beat with el_last.
REQ-007 in_ready SHALL be 1 only in IDLE.
REQ-008 On acceptance the sequencer SHALL register both vectors, fmt and scales; inputs SHALL be don't-care afterwards.
REQ-009 Illegal fmt accepted in IDLE SHALL pulse fmt_err the next cycle, stay in IDLE, leave outputs unchanged.
REQ-010 First beat SHALL present el_valid=1 the cycle after acceptance (latency 1).
REQ-011 Each beat SHALL carry elements el_idx..el_idx+LANES-1, lane k at bits [8k +: 8].
REQ-012 el_idx SHALL advance by LANES on el_valid&el_ready and hold otherwise; el_a/el_b/el_idx/el_last SHALL be stable while el_valid&!el_ready.
REQ-013 el_last SHALL be 1 exactly when el_idx==32-LANES; a block SHALL take 32/LANES accepted beats.
REQ-014 After the last beat the sequencer SHALL be in IDLE with in_ready=1 the following cycle; no back-to-back overlap (one bubble per block).
REQ-015 busy SHALL equal (state==ISSUE).
REQ-016 el_valid SHALL never drop without a handshake.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE, in_ready=1 after release, el_valid=0, el_last=0, el_idx=0, el_a=el_b=0, scale_a=scale_b=0, el_fmt=0, fmt_err=0, busy=0.
REQ-018 Reset mid-block SHALL abandon the block; no further beats.

Configuration
REQ-019 When MX_SEQ_SCALE_SUM_EN is defined, the block SHALL add output scale_sum (10-bit signed) = scale_a+scale_b-254, registered with the scales, plus scale_nan (1) set when either scale is 8'hFF; both SHALL reset to 0.
REQ-020 Without MX_SEQ_SCALE_SUM_EN, those ports and logic SHALL be absent; all else identical.

Structure
REQ-021 Format code enumeration, per-format element width function and scale NaN constant 8'hFF SHALL reside in mx_format_pkg alongside existing element and vector definitions.
REQ-022 Element extraction (vector, fmt, index -> 8-bit lane) SHALL be sub-module mx_elem_extract, instantiated 2*LANES times.

Verification
REQ-023 LANES=1, fmt=5, A element i = i, B element i = 8'hFF-i, el_ready=1 -> 32 beats, el_a=i, el_b=FF-i, el_last on idx 31, in_ready=1 next cycle.
REQ-024 LANES=4, fmt=4, A elements 4'hA, scale 8'h7F -> 8 beats, each el_a=32'h0A0A0A0A, scale_a=7F.
REQ-025 fmt=2, el_ready toggled 1/0 every cycle -> outputs stable on stall cycles, 64 cycles to complete, no element lost or duplicated.
REQ-026 fmt=7 offered -> fmt_err pulse one cycle, busy=0, in_ready stays 1, no el_valid.
REQ-027 rst_n asserted at idx 12 -> el_valid=0 immediately, after release in_ready=1, new block starts at idx 0.
REQ-028 MX_SEQ_SCALE_SUM_EN, scales 8'h80 and 8'h7E -> scale_sum=0, scale_nan=0; scale 8'hFF -> scale_nan=1.
